// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: valid/ready front end that decodes a 16-bit CPU byte address against a RAM window
// and drives a single-port block RAM. Optional macro MEM_ACCESS_CTRL_RD_REG_EN adds a read stage for RAMs with DO_REG=1.
module mem_access_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [15:0]           BASE_ADDR  = 16'h0000,
    parameter logic [DATA_WIDTH-1:0] FILL_DATA  = 8'hFF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [15:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_rd_enable,
    output logic [3:0]            mem_wr_enable,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    // Bits of the CPU address that select a RAM word; the remaining upper bits select the window.
    localparam logic [15:0] WIN_MASK = 16'((32'd1 << ADDR_WIDTH) - 32'd1);

    generate
        if ((ADDR_WIDTH < 1) || (ADDR_WIDTH > 16)) begin : g_bad_addr_width
            $error("mem_access_ctrl: ADDR_WIDTH must be in 1..16");
        end
        if ((BASE_ADDR & WIN_MASK) != 16'h0000) begin : g_bad_base_addr
            $error("mem_access_ctrl: BASE_ADDR must be aligned to the window size");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
`ifdef MEM_ACCESS_CTRL_RD_REG_EN
        ST_WAIT2 = 3'd3,
`endif
        ST_RESP  = 3'd4
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic                    we_r, we_nxt_s;
    logic                    req_ready_r, req_ready_nxt_s;
    logic                    rsp_valid_r, rsp_valid_nxt_s;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r, rsp_rdata_nxt_s;
    logic                    rsp_err_r, rsp_err_nxt_s;
    logic                    mem_rd_enable_r, mem_rd_enable_nxt_s;
    logic [3:0]              mem_wr_enable_r, mem_wr_enable_nxt_s;
    logic [ADDR_WIDTH-1:0]   mem_addr_r, mem_addr_nxt_s;
    logic [DATA_WIDTH-1:0]   mem_wr_data_r, mem_wr_data_nxt_s;
    logic                    accept_s;
    logic                    hit_s;

    assign accept_s = req_valid && req_ready_r;
    assign hit_s    = ((req_addr & ~WIN_MASK) == (BASE_ADDR & ~WIN_MASK));

    // Next-state and next-output decode; every output is computed here and registered below.
    always_comb begin
        state_nxt_s         = state_r;
        we_nxt_s            = we_r;
        rsp_valid_nxt_s     = rsp_valid_r;
        rsp_rdata_nxt_s     = rsp_rdata_r;
        rsp_err_nxt_s       = rsp_err_r;
        mem_rd_enable_nxt_s = 1'b0;
        mem_wr_enable_nxt_s = 4'h0;
        mem_addr_nxt_s      = mem_addr_r;
        mem_wr_data_nxt_s   = mem_wr_data_r;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    we_nxt_s = req_we;
                    if (hit_s) begin
                        state_nxt_s       = ST_ISSUE;
                        rsp_err_nxt_s     = 1'b0;
                        mem_addr_nxt_s    = req_addr[ADDR_WIDTH-1:0];
                        mem_wr_data_nxt_s = req_wdata;
                        if (req_we) begin
                            mem_wr_enable_nxt_s = 4'hF;
                        end else begin
                            mem_rd_enable_nxt_s = 1'b1;
                        end
                    end else begin
                        // Misses are answered directly and leave the RAM port untouched.
                        state_nxt_s     = ST_RESP;
                        rsp_valid_nxt_s = 1'b1;
                        rsp_err_nxt_s   = 1'b1;
                        rsp_rdata_nxt_s = req_we ? {DATA_WIDTH{1'b0}} : FILL_DATA;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (we_r) begin
                    state_nxt_s     = ST_RESP;
                    rsp_valid_nxt_s = 1'b1;
                    rsp_rdata_nxt_s = {DATA_WIDTH{1'b0}};
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
`ifdef MEM_ACCESS_CTRL_RD_REG_EN
            ST_WAIT: begin
                state_nxt_s = ST_WAIT2;
            end
            ST_WAIT2: begin
                state_nxt_s     = ST_RESP;
                rsp_valid_nxt_s = 1'b1;
                rsp_rdata_nxt_s = mem_rd_data;
            end
`else
            ST_WAIT: begin
                state_nxt_s     = ST_RESP;
                rsp_valid_nxt_s = 1'b1;
                rsp_rdata_nxt_s = mem_rd_data;
            end
`endif
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s     = ST_IDLE;
                    rsp_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                rsp_valid_nxt_s = 1'b0;
            end
        endcase

        req_ready_nxt_s = (state_nxt_s == ST_IDLE);
    end

    // State and output registers; reset discards any in-flight access and pending response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r         <= ST_IDLE;
            we_r            <= 1'b0;
            req_ready_r     <= 1'b1;
            rsp_valid_r     <= 1'b0;
            rsp_rdata_r     <= {DATA_WIDTH{1'b0}};
            rsp_err_r       <= 1'b0;
            mem_rd_enable_r <= 1'b0;
            mem_wr_enable_r <= 4'h0;
            mem_addr_r      <= {ADDR_WIDTH{1'b0}};
            mem_wr_data_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r         <= state_nxt_s;
            we_r            <= we_nxt_s;
            req_ready_r     <= req_ready_nxt_s;
            rsp_valid_r     <= rsp_valid_nxt_s;
            rsp_rdata_r     <= rsp_rdata_nxt_s;
            rsp_err_r       <= rsp_err_nxt_s;
            mem_rd_enable_r <= mem_rd_enable_nxt_s;
            mem_wr_enable_r <= mem_wr_enable_nxt_s;
            mem_addr_r      <= mem_addr_nxt_s;
            mem_wr_data_r   <= mem_wr_data_nxt_s;
        end
    end

    assign req_ready     = req_ready_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_rdata     = rsp_rdata_r;
    assign rsp_err       = rsp_err_r;
    assign mem_rd_enable = mem_rd_enable_r;
    assign mem_wr_enable = mem_wr_enable_r;
    assign mem_addr      = mem_addr_r;
    assign mem_wr_data   = mem_wr_data_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl (BASE 0, ADDR_WIDTH 12): directed cases, reset aborts and
// randomized requests checked against a transaction-level model of the window, latency and RAM contents.
module tb_mem_access_ctrl;

    localparam int DW = 8;
    localparam int AW = 12;
`ifdef MEM_ACCESS_CTRL_RD_REG_EN
    localparam int RD_LAT = 4;
`else
    localparam int RD_LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [15:0]   req_addr = 16'h0000;
    logic [DW-1:0] req_wdata = 8'h00;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          mem_rd_enable;
    logic [3:0]    mem_wr_enable;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] ram     [0:4095];
    logic [DW-1:0] ref_mem [0:4095];
    logic [DW-1:0] rd_q1, rd_q2;

    mem_access_ctrl dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_rd_enable(mem_rd_enable), .mem_wr_enable(mem_wr_enable), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    // Block RAM stand-in: one-cycle read, plus an output register when DO_REG is modelled.
    always @(posedge clk) begin
        if (mem_wr_enable == 4'hF) ram[mem_addr] <= mem_wr_data;
        if (mem_rd_enable) rd_q1 <= ram[mem_addr];
        rd_q2 <= rd_q1;
    end
`ifdef MEM_ACCESS_CTRL_RD_REG_EN
    assign mem_rd_data = rd_q2;
`else
    assign mem_rd_data = rd_q1;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
        check_eq({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check_eq({tag, "_mem_rd_en"}, 32'(mem_rd_enable), 32'd0);
        check_eq({tag, "_mem_wr_en"}, 32'(mem_wr_enable), 32'd0);
        check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check_eq({tag, "_mem_wr_data"}, 32'(mem_wr_data), 32'd0);
    endtask

    // Presents one request for exactly one accept edge, then scrambles the request bus.
    task automatic launch(input logic we, input logic [15:0] addr, input logic [DW-1:0] wd);
        @(negedge clk);
        check_eq("accept_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 8'($urandom);
    endtask

    task automatic do_req(input logic we, input logic [15:0] addr, input logic [DW-1:0] wd, input int stall);
        bit            hit;
        int            exp_lat;
        logic [DW-1:0] exp_rd;
        int            cyc;
        bit            seen;
        int            wr_cnt;
        int            rd_cnt;
        hit = (addr < 16'h1000);
        if (!hit) begin
            exp_lat = 1;
            exp_rd  = we ? 8'h00 : 8'hFF;
        end else if (we) begin
            exp_lat = 2;
            exp_rd  = 8'h00;
        end else begin
            exp_lat = RD_LAT;
            exp_rd  = ref_mem[addr[11:0]];
        end
        launch(we, addr, wd);
        if (hit && we) ref_mem[addr[11:0]] = wd;
        cyc = 0; seen = 1'b0; wr_cnt = 0; rd_cnt = 0;
        while (!seen && cyc < 16) begin
            @(negedge clk);
            if (mem_wr_enable != 4'h0) begin
                wr_cnt++;
                check_eq("wr_en_value", 32'(mem_wr_enable), 32'hF);
                check_eq("wr_addr", 32'(mem_addr), 32'(addr[11:0]));
                check_eq("wr_data", 32'(mem_wr_data), 32'(wd));
            end
            if (mem_rd_enable) begin
                rd_cnt++;
                check_eq("rd_addr", 32'(mem_addr), 32'(addr[11:0]));
            end
            if (rsp_valid) seen = 1'b1;
            else cyc++;
        end
        check_eq("rsp_latency", 32'(cyc + 1), 32'(exp_lat));
        check_eq("wr_pulses", 32'(wr_cnt), (hit && we) ? 32'd1 : 32'd0);
        check_eq("rd_pulses", 32'(rd_cnt), (hit && !we) ? 32'd1 : 32'd0);
        check_eq("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        check_eq("rsp_err", 32'(rsp_err), hit ? 32'd0 : 32'd1);
        check_eq("busy_ready", 32'(req_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_eq("stall_valid", 32'(rsp_valid), 32'd1);
            check_eq("stall_rdata", 32'(rsp_rdata), 32'(exp_rd));
            check_eq("stall_err", 32'(rsp_err), hit ? 32'd0 : 32'd1);
            check_eq("stall_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check_eq("post_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] v;
        bit            we;
        logic [15:0]   addr;
        int            sel;
        for (int i = 0; i < 4096; i++) begin
            v = 8'($urandom);
            ram[i] = v;
            ref_mem[i] = v;
        end

        // Reset held for three clocks, then released
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_release");

        // Directed cases: write, read-back, window miss, stalled response, miss write
        do_req(1'b1, 16'h0123, 8'hA5, 0);
        do_req(1'b0, 16'h0123, 8'h00, 0);
        do_req(1'b0, 16'h2000, 8'h00, 0);
        do_req(1'b0, 16'h0123, 8'h00, 5);
        do_req(1'b1, 16'hF000, 8'h11, 2);
        do_req(1'b0, 16'h0FFF, 8'h00, 1);
        do_req(1'b0, 16'h1000, 8'h00, 0);

        // Reset while the read waits for RAM data
        launch(1'b0, 16'h0123, 8'h00);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
            check_eq("idle_after_rst", 32'(req_ready), 32'd1);
        end

        // Reset during a write strobe drops it at once and the RAM keeps its old word
        launch(1'b1, 16'h0200, 8'h3C);
        #2;
        check_eq("abort_wr_pre", 32'(mem_wr_enable), 32'hF);
        resetn = 1'b0;
        #1;
        check_reset_outputs("rst_issue");
        @(negedge clk);
        resetn = 1'b1;
        do_req(1'b0, 16'h0200, 8'h00, 0);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            sel = $urandom_range(0, 3);
            we  = 1'($urandom);
            if (sel < 2)       addr = 16'h0120 + 16'($urandom_range(0, 15));
            else if (sel == 2) addr = 16'($urandom_range(0, 4095));
            else               addr = 16'($urandom_range(4096, 65535));
            do_req(we, addr, 8'($urandom), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
